// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared types and constants for the LED frame scheduler slice.
//   rgb_t          : one LED color word, GRB order, G in the MSBs.
//   frame_t        : a full color string for the default 6-LED strip.
//   sched_state_t  : scheduler FSM states.
//   LED_BITS       : bits per LED on the wire.
//   DEFAULT_LATCH_CYCLES : minimum low gap after a frame (300 us at 24 MHz).
// No ports (package).
// -----------------------------------------------------------------------------
package led_pkg;

   localparam int LED_BITS             = 24;
   localparam int DEFAULT_NUM_LEDS     = 6;
   localparam int DEFAULT_LATCH_CYCLES = 7200;
   localparam int FADE_MAX             = 4;

   typedef logic [LED_BITS-1:0] rgb_t;
   typedef logic [DEFAULT_NUM_LEDS*LED_BITS-1:0] frame_t;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      SEND      = 3'd2,
      LATCH     = 3'd3,
      WAIT_BEAT = 3'd4
   } sched_state_t;

endpackage

// File: rtl/led_frame_scheduler_frame_rotator.sv
// -----------------------------------------------------------------------------
// frame_rotator
// Combinational frame builder. LED k of the output shows palette LED
// (k + rot) mod NUM_LEDS; LED 0 sits in the MSBs of both vectors. A blank
// request forces the whole frame to zero.
// Build option: LED_FRAME_FADE_EN adds a fade input; every 8-bit channel is
// right-shifted by the fade level.
// Ports:
//   palette [24*NUM_LEDS] in  : base colors, GRB per LED
//   rot     [ROT_W]       in  : rotation amount in LEDs, 0..NUM_LEDS-1
//   blank                 in  : force an all-zero frame
//   fade    [3]           in  : channel shift 0..4 (LED_FRAME_FADE_EN only)
//   frame   [24*NUM_LEDS] out : rotated (and scaled) color string
// -----------------------------------------------------------------------------
module frame_rotator
   import led_pkg::*;
#(
   parameter int NUM_LEDS = 6,
   parameter int ROT_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic [LED_BITS*NUM_LEDS-1:0] palette,
   input  logic [ROT_W-1:0]             rot,
   input  logic                         blank,
`ifdef LED_FRAME_FADE_EN
   input  logic [2:0]                   fade,
`endif
   output logic [LED_BITS*NUM_LEDS-1:0] frame
);

   // One extra bit so k + rot never wraps before the modulo correction.
   localparam logic [ROT_W:0] NL = (ROT_W+1)'(NUM_LEDS);

   rgb_t leds [NUM_LEDS];

   for (genvar k = 0; k < NUM_LEDS; k++) begin : g_led
      localparam logic [ROT_W:0] K = (ROT_W+1)'(k);
      logic [ROT_W:0]   sum;
      logic [ROT_W-1:0] src;
      rgb_t             shown;

      assign leds[k] = palette[(NUM_LEDS-1-k)*LED_BITS +: LED_BITS];
      assign sum     = K + {1'b0, rot};
      // rot < NUM_LEDS, so a single subtraction completes the modulo.
      assign src     = (sum >= NL) ? ROT_W'(sum - NL) : ROT_W'(sum);
      assign shown   = leds[src];

`ifdef LED_FRAME_FADE_EN
      assign frame[(NUM_LEDS-1-k)*LED_BITS +: LED_BITS] =
         blank ? '0 : {shown[23:16] >> fade, shown[15:8] >> fade, shown[7:0] >> fade};
`else
      assign frame[(NUM_LEDS-1-k)*LED_BITS +: LED_BITS] = blank ? '0 : shown;
`endif
   end

endmodule

// File: rtl/led_frame_scheduler.sv
// -----------------------------------------------------------------------------
// led_frame_scheduler
// Drives the WS2812 shifter over a song: one frame per beat, each frame the
// base palette rotated one LED further. After NUM_BEATS beats a blank frame
// is sent and the block returns to idle.
// Build option: LED_FRAME_FADE_EN enables a 4-beat fade-in (see frame_rotator).
//
// Shifter handshake: frame_start is a one-cycle pulse while frame_data holds
// the new frame; frame_data then stays constant until the shifter answers
// with a one-cycle frame_done. If frame_done never arrives, DONE_TIMEOUT
// SEND cycles force completion and set the sticky timeout_err. After every
// frame the line is left idle for LATCH_CYCLES before the next frame_start.
//
// Ports:
//   clk          in  : 24 MHz system clock
//   reset        in  : synchronous, active-high
//   song_start   in  : pulse; starts (idle) or schedules a restart (busy)
//   beat_tick    in  : pulse per beat
//   palette      in  : base colors, GRB per LED, LED0 in MSBs
//   frame_done   in  : pulse from shifter, last bit sent
//   frame_start  out : pulse; shifter loads frame_data this cycle
//   frame_data   out : color string to shifter
//   beat_idx     out : beats consumed in the current song
//   active       out : high from song_start until the blank frame latched
//   timeout_err  out : sticky frame_done timeout flag, cleared by reset
// -----------------------------------------------------------------------------
module led_frame_scheduler
   import led_pkg::*;
#(
   parameter int NUM_LEDS     = 6,
   parameter int NUM_BEATS    = 32,
   parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
   parameter int DONE_TIMEOUT = 120000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          song_start,
   input  logic                          beat_tick,
   input  logic [LED_BITS*NUM_LEDS-1:0]  palette,
   input  logic                          frame_done,
   output logic                          frame_start,
   output logic [LED_BITS*NUM_LEDS-1:0]  frame_data,
   output logic [$clog2(NUM_BEATS+1)-1:0] beat_idx,
   output logic                          active,
   output logic                          timeout_err
);

   localparam int FW   = LED_BITS*NUM_LEDS;
   localparam int RW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int BW   = $clog2(NUM_BEATS+1);
   localparam int CMAX = (DONE_TIMEOUT > LATCH_CYCLES) ? DONE_TIMEOUT : LATCH_CYCLES;
   localparam int CW   = $clog2(CMAX+1);

   localparam logic [RW-1:0] ROT_LAST   = RW'(NUM_LEDS-1);
   localparam logic [BW-1:0] BEAT_LAST  = BW'(NUM_BEATS);
   localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES-1);
   localparam logic [CW-1:0] SEND_LAST  = CW'(DONE_TIMEOUT-1);

   sched_state_t  state_q, state_d;
   logic [FW-1:0] pal_q, pal_d;
   logic [FW-1:0] frame_q, rot_frame;
   logic [RW-1:0] rot_q, rot_d;
   logic [BW-1:0] beat_q, beat_d, beat_inc;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          blank_q, blank_d;
   logic          pending_q, pending_d;
   logic          restart_q, restart_d;
   logic          active_q, active_d;
   logic          terr_q, terr_d;
   logic          take_restart;
`ifdef LED_FRAME_FADE_EN
   logic [2:0]    fade_q, fade_d;
`endif

   assign beat_inc = beat_q + BW'(1);

   // The frame is built from next-cycle values so that it is already in
   // frame_q during the LOAD cycle, when frame_start is high.
   frame_rotator #(
      .NUM_LEDS (NUM_LEDS),
      .ROT_W    (RW)
   ) u_rotator (
      .palette  (pal_d),
      .rot      (rot_d),
      .blank    (blank_d),
`ifdef LED_FRAME_FADE_EN
      .fade     (fade_d),
`endif
      .frame    (rot_frame)
   );

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         pal_q     <= '0;
         frame_q   <= '0;
         rot_q     <= '0;
         beat_q    <= '0;
         cnt_q     <= '0;
         blank_q   <= 1'b0;
         pending_q <= 1'b0;
         restart_q <= 1'b0;
         active_q  <= 1'b0;
         terr_q    <= 1'b0;
`ifdef LED_FRAME_FADE_EN
         fade_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         pal_q     <= pal_d;
         rot_q     <= rot_d;
         beat_q    <= beat_d;
         cnt_q     <= cnt_d;
         blank_q   <= blank_d;
         pending_q <= pending_d;
         restart_q <= restart_d;
         active_q  <= active_d;
         terr_q    <= terr_d;
`ifdef LED_FRAME_FADE_EN
         fade_q    <= fade_d;
`endif
         if (state_d == LOAD) begin
            frame_q <= rot_frame;
         end
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d      = state_q;
      pal_d        = pal_q;
      rot_d        = rot_q;
      beat_d       = beat_q;
      cnt_d        = cnt_q;
      blank_d      = blank_q;
      pending_d    = pending_q;
      restart_d    = restart_q;
      active_d     = active_q;
      terr_d       = terr_q;
      take_restart = 1'b0;
`ifdef LED_FRAME_FADE_EN
      fade_d       = fade_q;
`endif

      // A beat arriving while a frame is in flight is remembered, one deep.
      if (beat_tick && (state_q == LOAD || state_q == SEND || state_q == LATCH)) begin
         pending_d = 1'b1;
      end

      // A restart never cuts a transfer short; it is acted on at the next
      // latch expiry (or at once if the block is just waiting for a beat).
      if (song_start && state_q != IDLE) begin
         restart_d = 1'b1;
         pal_d     = palette;
      end

      case (state_q)
         IDLE: begin
            if (song_start) begin
               pal_d     = palette;
               rot_d     = '0;
               beat_d    = '0;
               blank_d   = 1'b0;
               pending_d = 1'b0;
               restart_d = 1'b0;
               active_d  = 1'b1;
`ifdef LED_FRAME_FADE_EN
               fade_d    = 3'(FADE_MAX);
`endif
               state_d   = LOAD;
            end
         end

         LOAD: begin
            cnt_d   = '0;
            state_d = SEND;
         end

         SEND: begin
            // frame_done takes priority over a timeout in the same cycle.
            if (frame_done) begin
               cnt_d   = '0;
               state_d = LATCH;
            end else if (cnt_q == SEND_LAST) begin
               cnt_d   = '0;
               terr_d  = 1'b1;
               state_d = LATCH;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         LATCH: begin
            if (cnt_q == LATCH_LAST) begin
               cnt_d = '0;
               if (restart_q || song_start) begin
                  take_restart = 1'b1;
               end else if (blank_q) begin
                  active_d  = 1'b0;
                  blank_d   = 1'b0;
                  pending_d = 1'b0;
                  state_d   = IDLE;
               end else begin
                  state_d = WAIT_BEAT;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         WAIT_BEAT: begin
            if (song_start) begin
               take_restart = 1'b1;
            end else if (beat_tick || pending_q) begin
               beat_d    = beat_inc;
               pending_d = 1'b0;
               if (beat_inc == BEAT_LAST) begin
                  blank_d = 1'b1;
               end else begin
                  rot_d = (rot_q == ROT_LAST) ? '0 : rot_q + RW'(1);
               end
`ifdef LED_FRAME_FADE_EN
               if (fade_q != 3'd0) begin
                  fade_d = fade_q - 3'd1;
               end
`endif
               state_d = LOAD;
            end
         end

         default: state_d = IDLE;
      endcase

      // Restart: fresh song from the (re-latched) palette, unrotated.
      if (take_restart) begin
         rot_d     = '0;
         beat_d    = '0;
         blank_d   = 1'b0;
         pending_d = 1'b0;
         restart_d = 1'b0;
`ifdef LED_FRAME_FADE_EN
         fade_d    = 3'(FADE_MAX);
`endif
         state_d   = LOAD;
      end
   end

   // Outputs.
   always_comb begin
      frame_start = (state_q == LOAD);
      frame_data  = frame_q;
      beat_idx    = beat_q;
      active      = active_q;
      timeout_err = terr_q;
   end

endmodule

// File: doc/led_frame_scheduler.md
Name: led_frame_scheduler

Overview:
- Sequences the WS2812 LED shifter over the course of a song: builds each 6-LED frame and starts one shifter transfer per beat.
- Each frame is the base palette rotated by one LED per beat.
- Waits for the shifter's done pulse, then enforces the reset/latch gap. Sends a blank frame at song end.
- Sits between song timing (beat ticks) and the LED shifter, replacing the static color string tie-off at top level.

Parameters:
- NUM_LEDS, 6, LEDs in the string; frame width = 24*NUM_LEDS.
- NUM_BEATS, 32, beats per song; after the last, a blank frame is sent and the block goes idle.
- LATCH_CYCLES, 7200, minimum low gap after a frame (300 us at 24 MHz).
- DONE_TIMEOUT, 120000, cycles to wait for frame_done before forcing completion.

Ports:
- clk  in  1  24 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- song_start  in  1  one-cycle pulse; starts or restarts the show.
- beat_tick  in  1  one-cycle pulse per beat from song timing.
- palette  in  24*NUM_LEDS  base colors, GRB per LED, LED0 in MSBs; sampled at song_start.
- frame_done  in  1  one-cycle pulse from the shifter when the last bit has been sent.
- frame_start  out  1  one-cycle pulse; the shifter loads frame_data on this cycle.
- frame_data  out  24*NUM_LEDS  color string to the shifter; stable from frame_start until frame_done.
- beat_idx  out  $clog2(NUM_BEATS+1)  beats consumed in the current song.
- active  out  1  high from song_start until the blank frame has latched.
- timeout_err  out  1  sticky; set when DONE_TIMEOUT expires. Cleared only by reset.

Behaviour:
- Reset values: all outputs 0, state IDLE, pending_beat 0, restart 0, rot 0.
- States: IDLE, LOAD, SEND, LATCH, WAIT_BEAT.
- IDLE:
  - song_start: latch palette, rot=0, beat_idx=0, active=1, go to LOAD. The first frame is sent immediately, without waiting for a beat.
  - beat_tick in IDLE is ignored.
- LOAD (1 cycle):
  - Register frame_data = palette rotated left by rot*24 bits (LED k shows palette LED (k+rot) mod NUM_LEDS). In blank mode, frame_data = 0.
  - Assert frame_start for this single cycle, then go to SEND.
- SEND:
  - Wait for frame_done, then clear the counter and go to LATCH.
  - The timeout counter counts SEND cycles. On reaching DONE_TIMEOUT: set timeout_err and go to LATCH.
- LATCH:
  - Count LATCH_CYCLES. frame_start is held 0.
  - On expiry, exit in this priority order:
    1. restart flagged: rot=0, beat_idx=0, restart=0, pending_beat=0, go to LOAD.
    2. blank frame just latched: active=0, go to IDLE.
    3. Otherwise: go to WAIT_BEAT.
- WAIT_BEAT: on beat_tick, or with pending_beat set:
  - beat_idx+1.
  - If beat_idx becomes NUM_BEATS: blank mode, go to LOAD.
  - Otherwise: rot = (rot+1) mod NUM_LEDS, go to LOAD.
  - Clear pending_beat.
- beat_tick in LOAD, SEND or LATCH sets pending_beat. Pending is one deep; further beats are dropped, never queued.
- song_start outside IDLE sets restart. It never aborts a transfer in progress. The palette is re-latched at that moment.
- Simultaneous events:
  - beat_tick and song_start in the same cycle in WAIT_BEAT: song_start wins (restart path, beat discarded).
  - frame_done and timeout expiry in the same cycle: treated as done; timeout_err is not set.
- frame_done outside SEND is ignored.
- Synchronous reset mid-transfer returns to IDLE immediately. The shifter must be reset by the same signal.

Optional Feature:
- Macro LED_FRAME_FADE_EN.
- Defined:
  - Each frame's channels are scaled by a fade level of 0..4 (right shift by fade).
  - fade=4 on song_start; it decrements by 1 per beat down to 0, giving a fade-in over 4 beats.
  - Scaling is applied per 8-bit channel in LOAD, with no extra latency.
- Undefined: full brightness; no fade register is present.

Decomposition:
- Package led_pkg:
  - typedef rgb_t (24 bits) and the frame type.
  - state enum sched_state_t.
  - constants LED_BITS=24 and the default LATCH_CYCLES.
- One sub-module: frame_rotator. Combinational rotate, plus fade scaling when LED_FRAME_FADE_EN is defined.
- Counters and the FSM stay in led_frame_scheduler.

Test Plan:
- Reset, then song_start with palette A..F. Required: frame_start one cycle later, frame_data = A..F. Bench frame_done at +100; no frame_start within 7200 cycles of it.
- beat_tick in WAIT_BEAT. Required: next frame = B,C,D,E,F,A; beat_idx=1. After 6 beats the frame equals the original A..F again.
- Two beat_ticks during SEND. Required: exactly one further frame after LATCH, then wait for the next tick (beat_idx +1 only).
- NUM_BEATS=4: after the 4th beat, frame_data = 0. active drops LATCH_CYCLES after its frame_done; the block returns to IDLE.
- frame_done never returned. Required: timeout_err=1 at DONE_TIMEOUT, LATCH entered, sequence continues; error stays set until reset.
- song_start mid-SEND. Required: the transfer completes; after LATCH, frame_data = new palette unrotated, beat_idx=0.
